fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ResetAddr, default 32'h0000_0000, giving the first fetch PC after reset (bits [1:0] zero).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port redirect_valid_i, input, 1 bit: a branch, jump or trap redirect is present this cycle.
REQ-005 The block SHALL have port redirect_pc_i, input, 32 bits: the redirect target; bits [1:0] are ignored and treated as zero.
REQ-006 The block SHALL have port imem_req_valid_o, output, 1 bit: an instruction-memory read request is presented.
REQ-007 The block SHALL have port imem_req_ready_i, input, 1 bit: memory accepts the request.
REQ-008 The block SHALL have port imem_req_addr_o, output, 32 bits: the word-aligned request address.
REQ-009 The block SHALL have port imem_rsp_valid_i, input, 1 bit: read data returns; responses are in order, never earlier than the cycle after acceptance, and have no backpressure.
REQ-010 The block SHALL have port imem_rsp_data_i, input, 32 bits: the instruction word.
REQ-011 The block SHALL have port fifo_wr_valid_o, output, 1 bit: push to the downstream instruction FIFO.
REQ-012 The block SHALL have port fifo_wr_data_o, output, 64 bits: {pc[31:0], instr[31:0]}.
REQ-013 The block SHALL have port fifo_wr_ready_i, input, 1 bit: the FIFO has at least one free slot.
REQ-014 The block SHALL have port fifo_wr_ready_two_i, input, 1 bit: the FIFO has at least two free slots.

Function
REQ-015 The block SHALL hold req_pc (next address to request), rsp_pc (PC of the oldest fresh in-flight request), outstanding (0..2, every accepted request without a response) and stale (0..outstanding, in-flight requests made obsolete by a redirect).
REQ-016 The block SHALL drive imem_req_valid_o = !redirect_valid_i && outstanding<2 && (fresh==0 ? fifo_wr_ready_i : fifo_wr_ready_two_i), where fresh = outstanding - stale; each fresh request thereby has a guaranteed FIFO slot.
REQ-017 The block SHALL drive imem_req_addr_o = req_pc; on acceptance (valid && ready), req_pc SHALL advance by 4 with modulo-2^32 wrap and outstanding SHALL increment.
REQ-018 Once imem_req_valid_o is asserted and not yet accepted, the block SHALL keep it asserted with a stable address, except in a redirect cycle.
REQ-019 On a response, the block SHALL decrement outstanding; a simultaneous accept and response SHALL leave outstanding unchanged.
REQ-020 On a response with stale>0, the block SHALL drop the data, decrement stale, and keep fifo_wr_valid_o low.
REQ-021 On a response with stale==0 and no redirect, the block SHALL assert fifo_wr_valid_o in the same cycle (combinational) with data {rsp_pc, imem_rsp_data_i} and SHALL advance rsp_pc by 4.
REQ-022 fifo_wr_valid_o SHALL never be asserted while fifo_wr_ready_i is low; the credit rule of REQ-016 guarantees this, and an assertion checks it.
REQ-023 On redirect_valid_i, the block SHALL set req_pc and rsp_pc to {redirect_pc_i[31:2],2'b00}, set stale to outstanding - imem_rsp_valid_i, drop any response arriving that cycle, and issue no request that cycle.
REQ-024 On back-to-back redirects, the last one SHALL win, and stale SHALL be recomputed each cycle per REQ-023.
REQ-025 The block SHALL flush nothing downstream; the FIFO flush is owned by the consumer.

Reset
REQ-026 While rst_i is high, the block SHALL hold req_pc=rsp_pc=ResetAddr, outstanding=0, stale=0, imem_req_valid_o=0 and fifo_wr_valid_o=0; fifo_wr_data_o is don't-care.
REQ-027 After reset, the block SHALL issue its first request no earlier than the first clock edge after rst_i deasserts.
REQ-028 Asserting reset mid-operation SHALL discard all in-flight state; a bench holding imem_rsp_valid_i low during and after reset SHALL see no push.

Verification
REQ-029 The bench SHALL cover: reset release, ready FIFO, 1-cycle memory -> requests at 0x0, 0x4, 0x8 and pushes {0x0,I0}, {0x4,I1} in order.
REQ-030 The bench SHALL cover: fifo_wr_ready_two_i=0, fifo_wr_ready_i=1 -> at most one fresh request outstanding; no second request until the first returns.
REQ-031 The bench SHALL cover: two requests in flight (0x8, 0xC), then redirect to 0x103 -> next request 0x100; both old responses dropped; first push {0x100,Ix}.
REQ-032 The bench SHALL cover: a redirect in the same cycle a response arrives with outstanding=2 -> stale=1; that response and the next one are dropped.
REQ-033 The bench SHALL cover: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000; pushed PCs match.
REQ-034 The bench SHALL cover: a random FIFO-ready / memory-latency soak with a scoreboard -> no push while not ready, PCs strictly sequential between redirects, outstanding never exceeds 2.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. Issues sequential word-aligned
//             reads to instruction memory, pairs each returning word with
//             its PC and pushes {pc, instr} into a downstream FIFO. A redirect
//             retargets fetch immediately; requests already in flight when
//             the redirect lands are tracked as stale and their data dropped.
//             A request is only issued when the FIFO is guaranteed to have a
//             slot for its response, so responses never need backpressure.
//  Ports    : clk_i / rst_i           clock, asynchronous active-high reset
//             redirect_valid_i/pc_i   branch/jump/trap retarget
//             imem_req_*              instruction memory request channel
//             imem_rsp_*              in-order response channel, no stall
//             fifo_wr_*               push into the instruction FIFO
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        fifo_wr_valid_o,
    output logic [63:0] fifo_wr_data_o,
    input  logic        fifo_wr_ready_i,
    input  logic        fifo_wr_ready_two_i
);

    localparam logic [1:0]  C_MAX_OUTSTANDING = 2'd2;
    localparam logic [31:0] C_WORD_MASK       = 32'hFFFF_FFFC;
    localparam logic [31:0] C_WORD_BYTES      = 32'd4;

    logic [31:0] r_req_pc;
    logic [31:0] r_rsp_pc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_stale;
    // Low during reset and for the first edge after it, so no request can be
    // presented before a clock edge has been seen out of reset.
    logic        r_running;

    logic [1:0]  w_fresh;
    logic        w_credit;
    logic        w_accept;
    logic        w_rsp;
    logic        w_push;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc_i & C_WORD_MASK;

    // Fresh requests each own a FIFO slot: with one fresh response still to
    // come, a new request needs two free slots, otherwise one.
    assign w_fresh  = r_outstanding - r_stale;
    assign w_credit = (w_fresh == 2'd0) ? fifo_wr_ready_i : fifo_wr_ready_two_i;

    assign imem_req_valid_o = r_running && !redirect_valid_i
                              && (r_outstanding < C_MAX_OUTSTANDING) && w_credit;
    assign imem_req_addr_o  = r_req_pc;
    assign w_accept         = imem_req_valid_o && imem_req_ready_i;

    assign w_rsp            = r_running && imem_rsp_valid_i;
    assign w_push           = w_rsp && (r_stale == 2'd0) && !redirect_valid_i;
    assign fifo_wr_valid_o  = w_push;
    assign fifo_wr_data_o   = {r_rsp_pc, imem_rsp_data_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_pc      <= ResetAddr;
            r_rsp_pc      <= ResetAddr;
            r_outstanding <= 2'd0;
            r_stale       <= 2'd0;
            r_running     <= 1'b0;
        end else begin
            r_running     <= 1'b1;
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_rsp};

            if (redirect_valid_i) begin
                r_req_pc <= w_redirect_pc;
                r_rsp_pc <= w_redirect_pc;
                // Everything still in flight after this cycle is obsolete; a
                // response landing now is consumed (and dropped) this cycle.
                r_stale  <= r_outstanding - {1'b0, w_rsp};
            end else begin
                if (w_accept) begin
                    r_req_pc <= r_req_pc + C_WORD_BYTES;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + C_WORD_BYTES;
                end
                if (w_rsp && (r_stale != 2'd0)) begin
                    r_stale <= r_stale - 2'd1;
                end
            end
        end
    end

    // The credit rule above must make a push into a full FIFO impossible.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_wr_valid_o |-> fifo_wr_ready_i);

    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_outstanding <= C_MAX_OUTSTANDING) && (r_stale <= r_outstanding));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed and randomised self-checking bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_MAGIC = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fifo_wr_valid;
    logic [63:0] fifo_wr_data;
    logic        fifo_wr_ready;
    logic        fifo_wr_ready_two;

    int n_tests = 0;
    int n_fail  = 0;

    // Soak-phase models
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          last_due;
    int          occ;
    int          outs;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        acc;
    logic        push;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          lat;

    always #5 clk = ~clk;

    fetch_unit #(.ResetAddr(32'h0000_0000)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .redirect_valid_i    (redirect_valid),
        .redirect_pc_i       (redirect_pc),
        .imem_req_valid_o    (imem_req_valid),
        .imem_req_ready_i    (imem_req_ready),
        .imem_req_addr_o     (imem_req_addr),
        .imem_rsp_valid_i    (imem_rsp_valid),
        .imem_rsp_data_i     (imem_rsp_data),
        .fifo_wr_valid_o     (fifo_wr_valid),
        .fifo_wr_data_o      (fifo_wr_data),
        .fifo_wr_ready_i     (fifo_wr_ready),
        .fifo_wr_ready_two_i (fifo_wr_ready_two)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // one unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        imem_req_ready    = 1'b0;
        imem_rsp_valid    = 1'b0;
        imem_rsp_data     = 32'h0;
        fifo_wr_ready     = 1'b1;
        fifo_wr_ready_two = 1'b1;

        // ---------------- reset and release
        tick(); tick(); settle();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_wr_valid",  fifo_wr_valid, 0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        rst = 1'b0; settle();
        chk("release_no_req", imem_req_valid, 0);

        // ---------------- 1-cycle memory, sequential fetch
        tick(); imem_req_ready = 1'b1; settle();
        chk("seq_req0_valid", imem_req_valid, 1);
        chk("seq_req0_addr",  imem_req_addr, 32'h0);
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0000; settle();
        chk("seq_push0_valid", fifo_wr_valid, 1);
        chk("seq_push0_data",  fifo_wr_data, {32'h0, 32'h1111_0000});
        chk("seq_req1_addr",   imem_req_addr, 32'h4);
        tick(); imem_rsp_data = 32'h1111_0004; settle();
        chk("seq_push1_data",  fifo_wr_data, {32'h4, 32'h1111_0004});
        chk("seq_req2_addr",   imem_req_addr, 32'h8);

        // ---------------- two in flight (0x8, 0xC), redirect to 0x103
        tick(); imem_rsp_valid = 1'b0; settle();
        chk("rd_req3_addr", imem_req_addr, 32'hC);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103; settle();
        chk("rd_cycle_no_req",  imem_req_valid, 0);
        chk("rd_cycle_no_push", fifo_wr_valid, 0);
        tick(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0008; settle();
        chk("rd_drop0", fifo_wr_valid, 0);
        chk("rd_full_no_req", imem_req_valid, 0);
        tick(); imem_rsp_data = 32'hDEAD_000C; settle();
        chk("rd_drop1", fifo_wr_valid, 0);
        chk("rd_new_valid", imem_req_valid, 1);
        chk("rd_new_addr",  imem_req_addr, 32'h100);
        tick(); imem_rsp_data = 32'h2222_0100; imem_req_ready = 1'b0; settle();
        chk("rd_first_push_valid", fifo_wr_valid, 1);
        chk("rd_first_push_data",  fifo_wr_data, {32'h100, 32'h2222_0100});

        // ---------------- only one free slot: one fresh request at a time
        tick(); imem_rsp_valid = 1'b0; fifo_wr_ready_two = 1'b0; imem_req_ready = 1'b1; settle();
        chk("one_slot_req_valid", imem_req_valid, 1);
        chk("one_slot_req_addr",  imem_req_addr, 32'h104);
        tick(); settle();
        chk("one_slot_blocked", imem_req_valid, 0);
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_0104; settle();
        chk("one_slot_blocked_rsp", imem_req_valid, 0);
        chk("one_slot_push", fifo_wr_data, {32'h104, 32'h3333_0104});
        tick(); imem_rsp_valid = 1'b0; fifo_wr_ready_two = 1'b1; settle();
        chk("one_slot_next_valid", imem_req_valid, 1);
        chk("one_slot_next_addr",  imem_req_addr, 32'h108);

        // ---------------- redirect with a response in the same cycle, outstanding=2
        tick(); settle();
        chk("rr_req_10c", imem_req_addr, 32'h10C);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0108; settle();
        chk("rr_same_cycle_drop", fifo_wr_valid, 0);
        chk("rr_same_cycle_noreq", imem_req_valid, 0);
        tick(); redirect_valid = 1'b0; imem_rsp_data = 32'hDEAD_010C; imem_req_ready = 1'b0; settle();
        chk("rr_next_drop", fifo_wr_valid, 0);
        chk("rr_new_valid", imem_req_valid, 1);
        chk("rr_new_addr",  imem_req_addr, 32'h200);

        // ---------------- back-to-back redirects, last one wins; PC wrap
        tick(); imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; settle();
        chk("b2b_noreq", imem_req_valid, 0);
        tick(); redirect_pc = 32'hFFFF_FFFF; settle();
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; settle();
        chk("wrap_req0_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_FFFC; settle();
        chk("wrap_push0", fifo_wr_data, {32'hFFFF_FFFC, 32'h4444_FFFC});
        chk("wrap_req1_addr", imem_req_addr, 32'h0);
        tick(); imem_rsp_data = 32'h4444_0000; imem_req_ready = 1'b0; settle();
        chk("wrap_push1_valid", fifo_wr_valid, 1);
        chk("wrap_push1", fifo_wr_data, {32'h0, 32'h4444_0000});

        // ---------------- reset mid-operation with a request in flight
        tick(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; settle();
        chk("mid_req_addr", imem_req_addr, 32'h4);
        tick(); rst = 1'b1; settle();
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_wr_valid",  fifo_wr_valid, 0);
        chk("mid_rst_addr",      imem_req_addr, 32'h0);
        tick(); tick(); rst = 1'b0; settle();
        chk("mid_rel_wr_valid", fifo_wr_valid, 0);
        tick(); imem_req_ready = 1'b0; settle();
        chk("mid_after_wr_valid", fifo_wr_valid, 0);
        chk("mid_after_req_valid", imem_req_valid, 1);
        chk("mid_after_req_addr",  imem_req_addr, 32'h0);

        // ---------------- random soak with memory, FIFO and PC scoreboard
        occ = 0; outs = 0; last_due = 0;
        exp_pc = 32'h0; exp_req = 32'h0; prev_pending = 1'b0; prev_addr = 32'h0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            tick();
            redirect_valid    = ($urandom_range(0, 19) == 0);
            redirect_pc       = $urandom();
            imem_req_ready    = ($urandom_range(0, 9) < 7);
            fifo_wr_ready     = (occ < 4);
            fifo_wr_ready_two = (occ < 3);
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = q_addr[0] ^ C_MAGIC;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
            settle();

            acc  = imem_req_valid && imem_req_ready;
            push = fifo_wr_valid;

            if (prev_pending && !redirect_valid) begin
                chk("soak_req_held", imem_req_valid, 1);
                chk("soak_req_stable", imem_req_addr, prev_addr);
            end
            if (push) begin
                chk("soak_push_ready", fifo_wr_ready, 1);
                chk("soak_push_pc",    fifo_wr_data[63:32], exp_pc);
                chk("soak_push_data",  fifo_wr_data[31:0], exp_pc ^ C_MAGIC);
                exp_pc = exp_pc + 32'd4;
            end
            if (acc) begin
                chk("soak_req_seq", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                lat = $urandom_range(1, 3);
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                q_addr.push_back(imem_req_addr);
                q_due.push_back(last_due);
            end
            if (redirect_valid) begin
                chk("soak_redirect_noreq",  imem_req_valid, 0);
                chk("soak_redirect_nopush", fifo_wr_valid, 0);
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_req = redirect_pc & 32'hFFFF_FFFC;
            end
            if (imem_rsp_valid) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            outs = outs + int'(acc) - int'(imem_rsp_valid);
            chk("soak_outstanding_le2", (outs <= 2), 1);
            prev_pending = imem_req_valid && !acc;
            prev_addr    = imem_req_addr;
            if (occ > 0 && $urandom_range(0, 1) == 1) occ = occ - 1;
            if (push) occ = occ + 1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
